// File: rtl/beta_trap_ctrl.sv
// Machine-mode trap sequencer: picks one trap or mret, writes the trap CSRs over a handshaked port, then redirects fetch.
// Optional: define BETA_TRAP_MTVAL_EN to include the mtval write (W_TVAL); when undefined that state is skipped.
module beta_trap_ctrl #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   input  logic [1:0]      instr_trap_i,
   input  logic [1:0]      lsu_trap_i,
   input  logic            mret_i,
   input  logic            msip_i,
   input  logic            mtip_i,
   input  logic            meip_i,
   input  logic [XLEN-1:0] mie_i,
   input  logic [XLEN-1:0] mstatus_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [XLEN-1:0] lsu_addr_i,
   output logic            csr_we_o,
   output logic [11:0]     csr_addr_o,
   output logic [XLEN-1:0] csr_wdata_o,
   input  logic            csr_ack_i,
   output logic            stall_o,
   output logic            flush_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic [1:0]      tcu_trap_o
);

   typedef enum logic [1:0] {INSTR_NOTRAP, INSTR_MISALIG_FETCH, INSTR_ILLEGAL_FETCH} instr_trap_e;
   typedef enum logic [1:0] {LSU_NOTRAP, LSU_MISALIG_LOAD, LSU_MISALIG_STORE} lsu_trap_e;
   typedef enum logic [1:0] {TCU_NOTRAP, TCU_INTERRUPT, TCU_EXCEPTION} tcu_trap_e;
   typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, W_MRET, REDIRECT} state_e;

   state_e          state;
   logic            exc_sel, irq_sel, mret_sel;
   logic [4:0]      cause_d, cause_q;
   logic [XLEN-1:0] tval_d, base, trap_tgt, status_trap, status_mret;
   logic [XLEN-1:0] status_q, tgt_q;
`ifdef BETA_TRAP_MTVAL_EN
   logic [XLEN-1:0] tval_q;
`endif

   always_comb begin
      exc_sel = 1'b0;
      irq_sel = 1'b0;
      cause_d = '0;
      tval_d  = '0;
      if (valid_i) begin
         if (instr_trap_i == INSTR_MISALIG_FETCH) begin
            exc_sel = 1'b1; cause_d = 5'h00; tval_d = pc_i;
         end else if (instr_trap_i == INSTR_ILLEGAL_FETCH) begin
            exc_sel = 1'b1; cause_d = 5'h02; tval_d = instr_i;
         end else if (lsu_trap_i == LSU_MISALIG_LOAD) begin
            exc_sel = 1'b1; cause_d = 5'h04; tval_d = lsu_addr_i;
         end else if (lsu_trap_i == LSU_MISALIG_STORE) begin
            exc_sel = 1'b1; cause_d = 5'h06; tval_d = lsu_addr_i;
         end
      end
      if (!exc_sel && mstatus_i[3]) begin
         if (meip_i && mie_i[11]) begin
            irq_sel = 1'b1; cause_d = 5'h1b;
         end else if (msip_i && mie_i[3]) begin
            irq_sel = 1'b1; cause_d = 5'h13;
         end else if (mtip_i && mie_i[7]) begin
            irq_sel = 1'b1; cause_d = 5'h17;
         end
      end
      mret_sel = valid_i && mret_i && !exc_sel && !irq_sel;

      base     = {mtvec_i[XLEN-1:2], 2'b00};
      trap_tgt = (irq_sel && mtvec_i[1:0] == 2'b01) ? base + {26'b0, cause_d[3:0], 2'b00} : base;

      status_trap        = mstatus_i;
      status_trap[7]     = mstatus_i[3];
      status_trap[3]     = 1'b0;
      status_trap[12:11] = 2'b11;
      status_mret        = mstatus_i;
      status_mret[3]     = mstatus_i[7];
      status_mret[7]     = 1'b1;
      status_mret[12:11] = 2'b11;
   end

   logic unused_bits;
`ifdef BETA_TRAP_MTVAL_EN
   assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};
`else
   assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], tval_d};
`endif

   // Outputs are loaded for the state being entered, so they never depend combinationally on trap inputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         cause_q       <= '0;
         status_q      <= '0;
         tgt_q         <= '0;
`ifdef BETA_TRAP_MTVAL_EN
         tval_q        <= '0;
`endif
         csr_we_o      <= 1'b0;
         csr_addr_o    <= '0;
         csr_wdata_o   <= '0;
         stall_o       <= 1'b0;
         flush_o       <= 1'b0;
         redirect_o    <= 1'b0;
         redirect_pc_o <= '0;
         tcu_trap_o    <= TCU_NOTRAP;
      end else begin
         flush_o    <= 1'b0;
         redirect_o <= 1'b0;
         case (state)
            IDLE: begin
               if (exc_sel || irq_sel) begin
                  state       <= W_EPC;
                  cause_q     <= cause_d;
                  status_q    <= status_trap;
                  tgt_q       <= trap_tgt;
`ifdef BETA_TRAP_MTVAL_EN
                  tval_q      <= tval_d;
`endif
                  stall_o     <= 1'b1;
                  flush_o     <= 1'b1;
                  tcu_trap_o  <= irq_sel ? TCU_INTERRUPT : TCU_EXCEPTION;
                  csr_we_o    <= 1'b1;
                  csr_addr_o  <= 12'h341;
                  csr_wdata_o <= {pc_i[XLEN-1:2], 2'b00};
               end else if (mret_sel) begin
                  state       <= W_MRET;
                  tgt_q       <= mepc_i;
                  stall_o     <= 1'b1;
                  csr_we_o    <= 1'b1;
                  csr_addr_o  <= 12'h300;
                  csr_wdata_o <= status_mret;
               end
            end
            W_EPC: if (csr_ack_i) begin
               state       <= W_CAUSE;
               csr_addr_o  <= 12'h342;
               csr_wdata_o <= {cause_q[4], 27'b0, cause_q[3:0]};
            end
`ifdef BETA_TRAP_MTVAL_EN
            W_CAUSE: if (csr_ack_i) begin
               state       <= W_TVAL;
               csr_addr_o  <= 12'h343;
               csr_wdata_o <= tval_q;
            end
            W_TVAL: if (csr_ack_i) begin
               state       <= W_STATUS;
               csr_addr_o  <= 12'h300;
               csr_wdata_o <= status_q;
            end
`else
            W_CAUSE: if (csr_ack_i) begin
               state       <= W_STATUS;
               csr_addr_o  <= 12'h300;
               csr_wdata_o <= status_q;
            end
`endif
            W_STATUS, W_MRET: if (csr_ack_i) begin
               state         <= REDIRECT;
               csr_we_o      <= 1'b0;
               csr_addr_o    <= '0;
               csr_wdata_o   <= '0;
               redirect_o    <= 1'b1;
               redirect_pc_o <= tgt_q;
            end
            REDIRECT: begin
               state         <= IDLE;
               stall_o       <= 1'b0;
               tcu_trap_o    <= TCU_NOTRAP;
               redirect_pc_o <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
